// File: rtl/vote_pkg.sv
// Shared definitions for the vote collection front-end and its benches.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    localparam int NUM_VOTERS = 5;
    localparam int MAJ        = 3;

    function automatic logic [2:0] popcount5(input logic [NUM_VOTERS-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_VOTERS; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw button and debounces it with a stable-cycle counter.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES to a level change; rise is registered with it.
// Backpressure: none; free-running every cycle.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                // Level flips on the Nth consecutive disagreeing cycle.
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    rise  <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/vote_collector.sv
// Debounces five voter buttons, runs a timed session and captures the voter's decision.
// Latency: votes registered one cycle after a debounced edge; result captured on the DECIDE edge.
// Backpressure: none; start is ignored while busy, edges outside COLLECT are dropped.
module vote_collector
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int VOTE_WINDOW     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_VOTERS-1:0] btn,
    input  logic                  y_in,
    output logic [NUM_VOTERS-1:0] votes,
    output logic [2:0]            yes_count,
    output logic                  votes_valid,
    output logic                  busy,
    output logic                  result,
    output logic                  result_valid
);

    localparam logic [15:0]           TIMER_LOAD = 16'(VOTE_WINDOW - 1);
    localparam logic [NUM_VOTERS-1:0] ALL_YES    = '1;

    state_t                state, state_n;
    logic [NUM_VOTERS-1:0] votes_n;
    logic [15:0]           timer, timer_n;
    logic                  result_n, result_valid_n;
    logic [NUM_VOTERS-1:0] btn_level, btn_rise, vote_edge;

    for (genvar i = 0; i < NUM_VOTERS; i++) begin : g_deb
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn[i]),
            .level (btn_level[i]),
            .rise  (btn_rise[i])
        );
    end

    // A rise only ever accompanies a freshly high level; the AND guards stray pulses.
    assign vote_edge = btn_rise & btn_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            votes        <= '0;
            timer        <= '0;
            result       <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            votes        <= votes_n;
            timer        <= timer_n;
            result       <= result_n;
            result_valid <= result_valid_n;
        end
    end

    always_comb begin
        state_n        = state;
        votes_n        = votes;
        timer_n        = timer;
        result_n       = result;
        result_valid_n = result_valid;
        case (state)
            ST_IDLE, ST_SHOW: begin
                if (start) begin
                    votes_n        = '0;
                    timer_n        = TIMER_LOAD;
                    result_valid_n = 1'b0;
                    state_n        = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                votes_n = votes | vote_edge;
                if (timer != 16'd0) begin
                    timer_n = timer - 16'd1;
                end
                // Close on the last window cycle, or as soon as everyone has voted.
                if (timer == 16'd0 || votes_n == ALL_YES) begin
                    state_n = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                result_n       = y_in;
                result_valid_n = 1'b1;
                state_n        = ST_SHOW;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign votes_valid = (state == ST_DECIDE);
    assign busy        = (state == ST_COLLECT) || (state == ST_DECIDE);
    assign yes_count   = popcount5(votes);

endmodule
